// File: rtl/rns_mac_unit.sv
// Pipelined residue-number-system MAC unit: per-lane modular MUL/ADD/MAC/CLR
// across NUM_DOMAINS 8-bit lanes, valid/ready on both sides.
package rns_mac_pkg;
  typedef enum logic [1:0] {
    OP_MUL = 2'b00,
    OP_ADD = 2'b01,
    OP_MAC = 2'b10,
    OP_CLR = 2'b11
  } op_e;
endpackage

module rns_mac_unit
  import rns_mac_pkg::*;
#(
  parameter int unsigned              NUM_DOMAINS    = 2,
  parameter logic [9*NUM_DOMAINS-1:0] MODULI         = {9'd129, 9'd256},
  parameter int unsigned              LATENCY_STAGES = 3
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [1:0]                 in_op,
  input  logic [8*NUM_DOMAINS-1:0]   in_a,
  input  logic [8*NUM_DOMAINS-1:0]   in_b,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [8*NUM_DOMAINS-1:0]   out_result,
  output logic [NUM_DOMAINS-1:0]     out_err
);

  localparam int unsigned LW = 8;
  localparam int unsigned MW = 9;
  localparam int unsigned SW = 9;
  localparam int unsigned PW = 16;
  localparam int unsigned DW = LW * NUM_DOMAINS;
  localparam int unsigned S3 = LATENCY_STAGES - 1;

  logic                          w_adv;
  logic [NUM_DOMAINS-1:0]        w_in_err;
  logic [PW*NUM_DOMAINS-1:0]     w_prod;
  logic [SW*NUM_DOMAINS-1:0]     w_sum;
  logic [DW-1:0]                 w_pr;
  logic [DW-1:0]                 w_sr;
  logic [DW-1:0]                 w_mac;
  logic [DW-1:0]                 w_res;
  logic [DW-1:0]                 w_acc_next;

  logic [LATENCY_STAGES-1:0]     r_vld;
  op_e                           r_s1_op;
  logic [DW-1:0]                 r_s1_a;
  logic [DW-1:0]                 r_s1_b;
  logic [NUM_DOMAINS-1:0]        r_s1_err;
  op_e                           r_s2_op;
  logic [PW*NUM_DOMAINS-1:0]     r_s2_p;
  logic [SW*NUM_DOMAINS-1:0]     r_s2_s;
  logic [NUM_DOMAINS-1:0]        r_s2_err;
  op_e                           r_s3_op;
  logic [DW-1:0]                 r_s3_pr;
  logic [DW-1:0]                 r_s3_sr;
  logic [NUM_DOMAINS-1:0]        r_s3_err;
  logic [DW-1:0]                 r_acc;

  // Whole pipeline moves in lockstep; a full output register blocks everything.
  assign w_adv    = !out_valid || out_ready;
  assign in_ready = !reset || w_adv;

  // Per-lane datapath: range check, multiply/add, reduction and accumulate.
  for (genvar g = 0; g < NUM_DOMAINS; g++) begin : g_lane
    localparam logic [MW-1:0] M = MODULI[MW*g +: MW];

    logic [LW-1:0] w_a1;
    logic [LW-1:0] w_b1;
    logic [SW-1:0] w_acc_sum;

    assign w_a1 = r_s1_a[LW*g +: LW];
    assign w_b1 = r_s1_b[LW*g +: LW];

    assign w_in_err[g] = (MW'(in_a[LW*g +: LW]) >= M) || (MW'(in_b[LW*g +: LW]) >= M);

    assign w_prod[PW*g +: PW] = PW'(w_a1) * PW'(w_b1);
    assign w_sum[SW*g +: SW]  = SW'(w_a1) + SW'(w_b1);

    // Full reduction of the raw product/sum one stage ahead of the accumulator.
    assign w_pr[LW*g +: LW] = LW'(r_s2_p[PW*g +: PW] % PW'(M));
    assign w_sr[LW*g +: LW] = LW'(r_s2_s[SW*g +: SW] % M);

    // Both terms are below M, so one conditional subtract is exact.
    assign w_acc_sum = SW'(r_acc[LW*g +: LW]) + SW'(r_s3_pr[LW*g +: LW]);
    assign w_mac[LW*g +: LW] = (w_acc_sum >= M) ? LW'(w_acc_sum - M) : LW'(w_acc_sum);
  end

  // Result and accumulator selection for the entry in S3.
  always_comb begin
    w_res      = '0;
    w_acc_next = r_acc;
    case (r_s3_op)
      OP_MUL: w_res = r_s3_pr;
      OP_ADD: w_res = r_s3_sr;
      OP_MAC: begin
        w_res      = w_mac;
        w_acc_next = w_mac;
      end
      OP_CLR: w_acc_next = '0;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_vld      <= '0;
      r_s1_op    <= OP_MUL;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
      r_s1_err   <= '0;
      r_s2_op    <= OP_MUL;
      r_s2_p     <= '0;
      r_s2_s     <= '0;
      r_s2_err   <= '0;
      r_s3_op    <= OP_MUL;
      r_s3_pr    <= '0;
      r_s3_sr    <= '0;
      r_s3_err   <= '0;
      r_acc      <= '0;
      out_valid  <= 1'b0;
      out_result <= '0;
      out_err    <= '0;
    end else if (w_adv) begin
      r_vld <= {r_vld[S3-1:0], in_valid};

      if (in_valid) begin
        r_s1_op  <= op_e'(in_op);
        r_s1_a   <= in_a;
        r_s1_b   <= in_b;
        r_s1_err <= w_in_err;
      end

      r_s2_op  <= r_s1_op;
      r_s2_p   <= w_prod;
      r_s2_s   <= w_sum;
      r_s2_err <= r_s1_err;

      r_s3_op  <= r_s2_op;
      r_s3_pr  <= w_pr;
      r_s3_sr  <= w_sr;
      r_s3_err <= r_s2_err;

      // Bubbles leave the accumulators and the visible result untouched.
      out_valid <= r_vld[S3];
      if (r_vld[S3]) begin
        out_result <= w_res;
        out_err    <= r_s3_err;
        r_acc      <= w_acc_next;
      end
    end
  end

endmodule

// File: tb/tb_rns_mac_unit.sv
// Scoreboard bench for rns_mac_unit: directed cases plus randomized traffic
// with random back-pressure, checked against a plain-arithmetic residue model.
module tb_rns_mac_unit;

  localparam int unsigned ND = 2;
  localparam int unsigned DW = 8 * ND;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    in_op;
  logic [DW-1:0] in_a;
  logic [DW-1:0] in_b;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_result;
  logic [ND-1:0] out_err;

  rns_mac_unit #(
    .NUM_DOMAINS   (ND),
    .MODULI        ({9'd129, 9'd256}),
    .LATENCY_STAGES(3)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_result(out_result),
    .out_err   (out_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ND-1:0] err;
    logic [DW-1:0] res;
  } exp_t;

  exp_t          q[$];
  int            mods[ND] = '{256, 129};
  int            m_acc[ND];
  int            n_vec = 0;
  int            n_err = 0;
  bit            rand_bp = 0;
  logic [DW-1:0] last_exp = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Residue arithmetic straight from the operation definitions.
  task automatic model(input logic [1:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                       output exp_t e);
    e = '0;
    for (int i = 0; i < ND; i++) begin
      int ai, bi, m, r;
      m  = mods[i];
      ai = int'(a[8*i +: 8]);
      bi = int'(b[8*i +: 8]);
      e.err[i] = (ai >= m) || (bi >= m);
      case (op)
        2'b00: r = (ai * bi) % m;
        2'b01: r = (ai + bi) % m;
        2'b10: begin
          r = (m_acc[i] + ai * bi) % m;
          m_acc[i] = r;
        end
        default: begin
          r = 0;
          m_acc[i] = 0;
        end
      endcase
      e.res[8*i +: 8] = 8'(r);
    end
  endtask

  task automatic issue(input logic [1:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input bit use_exp, input logic [DW-1:0] er, input logic [ND-1:0] ee);
    exp_t e;
    bit   ok;
    bit   done = 0;
    int   guard = 0;
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    while (!done) begin
      if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      if (ok) begin
        model(op, a, b, e);
        if (use_exp) begin
          e.res = er;
          e.err = ee;
        end
        q.push_back(e);
        done = 1;
      end
      #1;
      guard++;
      if (!done && guard > 200) begin
        n_vec++;
        n_err++;
        $display("FAIL issue_timeout: in_ready low for %0d cycles, expected acceptance", guard);
        done = 1;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    int guard = 0;
    out_ready = 1'b1;
    while (q.size() != 0 && guard < 100) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain_timeout: %0d results outstanding, expected 0", q.size());
      q.delete();
    end
  endtask

  function automatic logic [DW-1:0] rnd_legal();
    return {8'($urandom_range(0, 128)), 8'($urandom)};
  endfunction

  // Monitor: every result the consumer takes is compared with the queue head.
  always @(negedge clk) begin
    exp_t e;
    if (reset === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_output: got res=0x%0h err=%b, expected no output",
                 out_result, out_err);
      end else begin
        e = q.pop_front();
        chk("result", 32'({out_err, out_result}), 32'(e));
        last_exp = e.res;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < ND; i++) m_acc[i] = 0;
    out_ready = 1'b1;

    // Reset held with traffic offered
    reset    = 1'b0;
    in_valid = 1'b1;
    in_op    = 2'b10;
    in_a     = 16'hFFFF;
    in_b     = 16'hFFFF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid",  32'(out_valid),  32'd0);
    chk("rst_out_result", 32'(out_result), 32'd0);
    chk("rst_out_err",    32'(out_err),    32'd0);
    chk("rst_in_ready",   32'(in_ready),   32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    reset    = 1'b1;

    issue(2'b11, 16'h0000, 16'h0000, 1, 16'h0000, 2'b00);
    issue(2'b10, 16'h0000, 16'h0000, 1, 16'h0000, 2'b00);

    // MUL, ADD, then CLR/MAC/MAC back to back
    issue(2'b00, 16'h64C8, 16'h3203, 1, 16'h6258, 2'b00);
    issue(2'b01, 16'h64C8, 16'h3203, 1, 16'h15CB, 2'b00);
    issue(2'b11, 16'h64C8, 16'h3203, 1, 16'h0000, 2'b00);
    issue(2'b10, 16'h64C8, 16'h3203, 1, 16'h6258, 2'b00);
    issue(2'b10, 16'h64C8, 16'h3203, 1, 16'h43B0, 2'b00);
    drain();
    idle(2);

    // Back-pressure: consumer stalls for 4 cycles after the first result
    fork
      begin
        for (int k = 0; k < 5; k++) issue(2'b00, rnd_legal(), rnd_legal(), 0, '0, '0);
      end
      begin
        int g = 0;
        do begin
          @(negedge clk);
          g++;
        end while (!(out_valid && out_ready) && g < 50);
        if (g >= 50) begin
          n_vec++;
          n_err++;
          $display("FAIL bp_first_result: no result within %0d cycles, expected one", g);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (4) begin
          @(negedge clk);
          chk("bp_in_ready", 32'(in_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Accumulators untouched by the stalled MUL stream
    issue(2'b10, 16'h0000, 16'h0000, 1, 16'h43B0, 2'b00);

    // Out-of-range lane-1 operand
    issue(2'b00, 16'h8205, 16'h0107, 1, 16'h0123, 2'b10);
    drain();
    idle(3);
    @(negedge clk);
    chk("hold_out_valid",  32'(out_valid),  32'd0);
    chk("hold_out_result", 32'(out_result), 32'(last_exp));
    @(posedge clk);
    #1;

    // Reset mid-stream: two MACs in flight, a third offered during reset
    issue(2'b10, rnd_legal(), rnd_legal(), 0, '0, '0);
    issue(2'b10, rnd_legal(), rnd_legal(), 0, '0, '0);
    reset    = 1'b0;
    in_valid = 1'b1;
    in_op    = 2'b10;
    in_a     = rnd_legal();
    in_b     = rnd_legal();
    q.delete();
    for (int i = 0; i < ND; i++) m_acc[i] = 0;
    repeat (2) begin
      @(negedge clk);
      chk("midrst_out_valid", 32'(out_valid), 32'd0);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    reset    = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("postrst_quiet", 32'(out_valid), 32'd0);
      @(posedge clk);
      #1;
    end
    issue(2'b10, 16'h0101, 16'h0101, 1, 16'h0101, 2'b00);
    drain();

    // Randomized traffic with random back-pressure and idle gaps
    rand_bp = 1;
    for (int k = 0; k < 300; k++) begin
      issue(2'($urandom_range(0, 3)), 16'($urandom), 16'($urandom), 0, '0, '0);
      if ($urandom_range(0, 7) == 0) idle(int'($urandom_range(1, 3)));
    end
    rand_bp = 0;
    drain();
    idle(4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rns_mac_unit.md
Name: rns_mac_unit

Overview:
Parametrised, pipelined residue-number-system arithmetic unit for the RNS processor datapath. It performs modular multiply, add, multiply-accumulate and accumulator clear independently in NUM_DOMAINS residue lanes, each with its own modulus. It sits beside the EX stage as a multi-cycle functional unit, with a valid/ready handshake so the pipeline can stall on back-pressure. It generalises the single-cycle per-domain ALU path to arbitrary domain count, per-lane accumulators and operand range checking.

Parameters:
NUM_DOMAINS, 2, number of residue lanes; each lane is 8 bits wide.
MODULI, {9'd129, 9'd256}, packed 9-bit moduli; lane i uses MODULI[9i+8:9i], legal range 2..256.
LATENCY_STAGES, 3, pipeline depth; fixed at 3 (S1 capture, S2 multiply, S3 reduce/accumulate).

Ports:
clk  in  1  clock; all state updates on its rising edge.
reset  in  1  synchronous, active-low reset.
in_valid  in  1  operand/op presented.
in_ready  out  1  unit accepts the operand this cycle.
in_op  in  2  operation: 00 MUL, 01 ADD, 10 MAC, 11 CLR.
in_a  in  8*NUM_DOMAINS  operand A residues; lane i is bits [8i+7:8i].
in_b  in  8*NUM_DOMAINS  operand B residues, same packing.
out_valid  out  1  result available.
out_ready  in  1  consumer takes the result.
out_result  out  8*NUM_DOMAINS  residue result per lane.
out_err  out  NUM_DOMAINS  per lane: an input residue was >= that lane's modulus.

Behaviour:
- Reset (reset==0 at a clock edge): all stage valid bits, out_valid, out_result, out_err and all lane accumulators are cleared to 0. in_ready = 1 during and after reset. Reset mid-operation discards every in-flight operation; nothing is emitted.
- Advance condition: adv = !out_valid || out_ready. When adv==1 all stages shift. When adv==0 all stages hold, including the accumulators. in_ready = adv, combinational.
- A transfer occurs when in_valid && in_ready. Without a transfer, a bubble (valid=0) enters S1.
- Latency: an operand accepted at edge N gives out_valid=1 after edge N+3, provided there is no back-pressure. Throughput is 1 op/cycle. Results leave in strict order.
- S1: registers op, a, b and err, where err[i] = (a_i >= m_i) || (b_i >= m_i). Operands are not pre-reduced.
- S2: per lane, 16-bit product p_i = a_i*b_i and 9-bit sum s_i = a_i+b_i.
- S3, per lane, with all results exact residues in 0..m_i-1:
  - MUL: r = p mod m.
  - ADD: r = s mod m.
  - MAC: r = (acc + p) mod m; acc <= r.
  - CLR: acc <= 0; r = 0.
  - The accumulator updates only when a valid S3 entry advances.
- Back-to-back MACs in one lane need no stall. Each MAC sees the accumulator written by the previous MAC, because update and use are both in S3.
- Modulus 256 reduces to the low 8 bits. Modulus 129 must handle p up to 65025. The implementation may use any exact method.
- out_err: this is a diagnostic only. The result is still the true residue of the unreduced input arithmetic.
- Bubbles never modify the accumulators or out_result. out_result holds its last value while out_valid==0.
- Simultaneous accept and emit in the same cycle is legal and loses nothing.

Test Plan:
- Reset: hold reset=0 for 2 cycles with in_valid=1 -> out_valid=0, out_result=0, out_err=0, in_ready=1; after release, a CLR then MAC with a=b=0 -> result {0,0}.
- MUL: a={100,200}, b={50,3} (lane1,lane0) -> 3 cycles later out_result={98,88}, out_err=00.
- ADD then MAC chain: ADD with the same operands -> {21,203}. Then CLR, MAC, MAC back-to-back with the same operands -> results {0,0}, {98,88}, {67,176}.
- Back-pressure: stream 5 MULs with out_ready=0 from the 2nd result onward for 4 cycles -> in_ready=0 while stalled. All 5 results emerge in order, no drop or duplicate, and accumulators are unchanged.
- Out-of-range input: lane1 a=130, b=1, MUL -> out_err=2'b10, lane1 result=1.
- Reset mid-stream: issue 3 MACs, assert reset after the 2nd is accepted -> no outputs, accumulators cleared; the next MAC with a={1,1}, b={1,1} -> {1,1}.
